// File: rtl/sal_host_data_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sal_host_if_pkg
// Purpose  : Shared constants for the SAL host data-channel adapter.
// Revision : 1.0 - initial release
// ============================================================================
package sal_host_if_pkg;

    localparam logic [31:0] REG_ID     = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL   = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS = 32'h0000_0008;
    localparam logic [31:0] REG_WCNT   = 32'h0000_000C;
    localparam logic [31:0] REG_RCNT   = 32'h0000_0010;

    localparam logic [31:0] ID_VALUE   = 32'h5341_4C31;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    localparam logic [1:0]  W_BEAT0    = 2'd0;
    localparam logic [1:0]  W_BEAT1    = 2'd1;
    localparam logic [1:0]  W_FULL     = 2'd2;

    localparam logic [1:0]  R_IDLE     = 2'd0;
    localparam logic [1:0]  R_LO       = 2'd1;
    localparam logic [1:0]  R_HI       = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sal_host_data_if_if.sv
`default_nettype none
// ============================================================================
// Module   : sal_host_data_if_if
// Purpose  : APB, AXI W/R and controller queue signals of the host adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface sal_host_data_if_if #(
    parameter int ID_W   = 4,
    parameter int BEAT_W = 128,
    parameter int APB_AW = 12
);
    logic [APB_AW-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [31:0]         pwdata;
    logic [31:0]         prdata;
    logic                pready;
    logic                pslverr;

    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     wid;
    logic [BEAT_W-1:0]   wdata;
    logic [BEAT_W/8-1:0] wstrb;
    logic                wlast;

    logic                wq_valid;
    logic                wq_ready;
    logic [ID_W-1:0]     wq_id;
    logic [2*BEAT_W-1:0] wq_data;
    logic [BEAT_W/4-1:0] wq_strb;

    logic                rq_valid;
    logic                rq_ready;
    logic [ID_W-1:0]     rq_id;
    logic [2*BEAT_W-1:0] rq_data;

    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     rid;
    logic [BEAT_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr,
        input  wvalid, wid, wdata, wstrb, wlast,
        output wready,
        output wq_valid, wq_id, wq_data, wq_strb,
        input  wq_ready,
        input  rq_valid, rq_id, rq_data,
        output rq_ready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr,
        output wvalid, wid, wdata, wstrb, wlast,
        input  wready,
        input  wq_valid, wq_id, wq_data, wq_strb,
        output wq_ready,
        output rq_valid, rq_id, rq_data,
        input  rq_ready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

endinterface
`default_nettype wire

// File: rtl/sal_host_data_if_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : sal_host_apb_regs
// Purpose  : Zero-wait APB register file: ID, CTRL.EN, STATUS.WERR, counters.
// Revision : 1.0 - initial release
// ============================================================================
module sal_host_apb_regs
    import sal_host_if_pkg::*;
#(
    parameter int APB_AW = 12
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [APB_AW-1:0] i_paddr,
    input  wire logic              i_psel,
    input  wire logic              i_penable,
    input  wire logic              i_pwrite,
    input  wire logic [31:0]       i_pwdata,
    output logic      [31:0]       o_prdata,
    output logic                   o_pready,
    output logic                   o_pslverr,
    input  wire logic              i_werr_set,
    input  wire logic              i_wcnt_inc,
    input  wire logic              i_rcnt_inc,
    output logic                   o_en
);

    logic        r_en;
    logic        r_werr;
    logic [31:0] r_wcnt;
    logic [31:0] r_rcnt;

    logic        w_access;
    logic        w_hit;
    logic        w_ro;
    logic        w_err;
    logic        w_wr_ok;
    logic [31:0] w_val;
    logic [31:0] w_addr;
    logic        w_unused;

    assign w_access = i_psel && i_penable;
    assign w_addr   = 32'(i_paddr);
    assign w_unused = ^i_pwdata[31:1];

    always_comb begin
        w_val = '0;
        w_hit = 1'b1;
        w_ro  = 1'b1;
        case (w_addr)
            REG_ID:     w_val = ID_VALUE;
            REG_CTRL:   begin w_val = {31'b0, r_en};   w_ro = 1'b0; end
            REG_STATUS: begin w_val = {31'b0, r_werr}; w_ro = 1'b0; end
            REG_WCNT:   w_val = r_wcnt;
            REG_RCNT:   w_val = r_rcnt;
            default:    w_hit = 1'b0;
        endcase
    end

    // Faulting accesses return zero data and leave every register untouched
    assign w_err     = w_access && (!w_hit || (i_pwrite && w_ro));
    assign w_wr_ok   = w_access && i_pwrite && !w_err;
    assign o_pslverr = w_err;
    assign o_prdata  = (w_access && !i_pwrite && !w_err) ? w_val : '0;
    assign o_pready  = 1'b1;
    assign o_en      = r_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= 1'b1;
            r_werr <= 1'b0;
            r_wcnt <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_wr_ok && w_addr == REG_CTRL)
                r_en <= i_pwdata[0];
            // A new error in the clearing cycle wins over the clear
            r_werr <= i_werr_set ||
                      (r_werr && !(w_wr_ok && w_addr == REG_STATUS && i_pwdata[0]));
            if (i_wcnt_inc)
                r_wcnt <= r_wcnt + 32'd1;
            if (i_rcnt_inc)
                r_rcnt <= r_rcnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sal_host_data_if.sv
`default_nettype none
// ============================================================================
// Module   : sal_host_data_if
// Purpose  : Packs AXI W beat pairs into 256-bit entries and splits read
//            entries into AXI R beat pairs; APB control/status.
// Revision : 1.0 - initial release
// ============================================================================
module sal_host_data_if
    import sal_host_if_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int BEAT_W = 128,
    parameter int APB_AW = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sal_host_data_if_if.slave bus
);

    localparam int SW = BEAT_W / 8;

    logic w_en;
    logic w_werr_set;
    logic w_wcnt_inc;
    logic w_rcnt_inc;

    // ------------------------------------------------------------ write path
    logic [1:0]          r_wstate;
    logic [ID_W-1:0]     r_wq_id;
    logic [2*BEAT_W-1:0] r_wq_data;
    logic [2*SW-1:0]     r_wq_strb;

    logic w_wready;
    logic w_wq_valid;
    logic w_w_hs;

    assign w_wready   = w_en && !rst && (r_wstate != W_FULL || bus.wq_ready);
    assign w_wq_valid = (r_wstate == W_FULL);
    assign w_w_hs     = bus.wvalid && w_wready;
    assign w_wcnt_inc = w_wq_valid && bus.wq_ready;
    // Error: wlast on the first beat of a pair, or missing on the second
    assign w_werr_set = w_w_hs && ((r_wstate == W_BEAT1) ? !bus.wlast : bus.wlast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_BEAT0;
            r_wq_id   <= '0;
            r_wq_data <= '0;
            r_wq_strb <= '0;
        end else if (w_w_hs) begin
            if (r_wstate == W_BEAT1) begin
                r_wq_data[2*BEAT_W-1:BEAT_W] <= bus.wdata;
                r_wq_strb[2*SW-1:SW]         <= bus.wstrb;
                r_wstate                     <= W_FULL;
            end else begin
                // BEAT0, or FULL being drained this cycle: start a new pair
                r_wq_data[BEAT_W-1:0] <= bus.wdata;
                r_wq_strb[SW-1:0]     <= bus.wstrb;
                r_wq_id               <= bus.wid;
                if (bus.wlast) begin
                    r_wq_data[2*BEAT_W-1:BEAT_W] <= '0;
                    r_wq_strb[2*SW-1:SW]         <= '0;
                    r_wstate                     <= W_FULL;
                end else begin
                    r_wstate <= W_BEAT1;
                end
            end
        end else if (w_wcnt_inc) begin
            r_wstate <= W_BEAT0;
        end
    end

    assign bus.wready   = w_wready;
    assign bus.wq_valid = w_wq_valid;
    assign bus.wq_id    = r_wq_id;
    assign bus.wq_data  = r_wq_data;
    assign bus.wq_strb  = r_wq_strb;

    // ------------------------------------------------------------- read path
    logic [1:0]        r_rstate;
    logic [ID_W-1:0]   r_rid;
    logic [BEAT_W-1:0] r_rdata;
    logic [BEAT_W-1:0] r_rhi;
    logic              r_rlast;

    logic w_rq_ready;
    logic w_rq_hs;

    assign w_rq_ready = w_en && !rst &&
                        (r_rstate == R_IDLE || (r_rstate == R_HI && bus.rready));
    assign w_rq_hs    = bus.rq_valid && w_rq_ready;
    assign w_rcnt_inc = (r_rstate == R_HI) && bus.rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rhi    <= '0;
            r_rlast  <= 1'b0;
        end else if (w_rq_hs) begin
            r_rdata  <= bus.rq_data[BEAT_W-1:0];
            r_rhi    <= bus.rq_data[2*BEAT_W-1:BEAT_W];
            r_rid    <= bus.rq_id;
            r_rlast  <= 1'b0;
            r_rstate <= R_LO;
        end else if (r_rstate == R_LO && bus.rready) begin
            r_rdata  <= r_rhi;
            r_rlast  <= 1'b1;
            r_rstate <= R_HI;
        end else if (r_rstate == R_HI && bus.rready) begin
            r_rlast  <= 1'b0;
            r_rstate <= R_IDLE;
        end
    end

    assign bus.rq_ready = w_rq_ready;
    assign bus.rvalid   = (r_rstate != R_IDLE);
    assign bus.rid      = r_rid;
    assign bus.rdata    = r_rdata;
    assign bus.rresp    = RESP_OKAY;
    assign bus.rlast    = r_rlast;

    // -------------------------------------------------------------- registers
    sal_host_apb_regs #(
        .APB_AW (APB_AW)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .i_paddr    (bus.paddr),
        .i_psel     (bus.psel),
        .i_penable  (bus.penable),
        .i_pwrite   (bus.pwrite),
        .i_pwdata   (bus.pwdata),
        .o_prdata   (bus.prdata),
        .o_pready   (bus.pready),
        .o_pslverr  (bus.pslverr),
        .i_werr_set (w_werr_set),
        .i_wcnt_inc (w_wcnt_inc),
        .i_rcnt_inc (w_rcnt_inc),
        .o_en       (w_en)
    );

endmodule
`default_nettype wire

// File: tb/tb_sal_host_data_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_sal_host_data_if
// Purpose  : Directed self-checking bench for sal_host_data_if.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sal_host_data_if;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sal_host_data_if_if #(.ID_W(4), .BEAT_W(128), .APB_AW(12)) bus ();

    sal_host_data_if #(.ID_W(4), .BEAT_W(128), .APB_AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        rd  = bus.prdata;
        err = bus.pslverr;
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [127:0] d,
                          input logic [15:0] s, input bit last);
        bit ok;
        ok = 1'b0;
        bus.wvalid = 1'b1; bus.wid = id; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            ok = bus.wready;
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check("w_accept", 256'(ok), 256'd1);
    endtask

    task automatic wq_take();
        bus.wq_ready = 1'b1;
        @(negedge clk);
        bus.wq_ready = 1'b0;
        check("wq_drained", 256'(bus.wq_valid), 256'd0);
    endtask

    task automatic chk_r(input string tag, input logic [127:0] d, input logic [3:0] id, input bit last);
        check({tag, "_rvalid"}, 256'(bus.rvalid), 256'd1);
        check({tag, "_rdata"},  256'(bus.rdata),  256'(d));
        check({tag, "_rid"},    256'(bus.rid),    256'(id));
        check({tag, "_rlast"},  256'(bus.rlast),  256'(last));
        check({tag, "_rresp"},  256'(bus.rresp),  256'd0);
    endtask

    logic [31:0]  rd;
    logic         err;
    logic [255:0] rq0, rq1, rq2;

    initial begin
        bus.paddr = '0; bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.pwdata = '0;
        bus.wvalid = 0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
        bus.wq_ready = 0; bus.rq_valid = 0; bus.rq_id = '0; bus.rq_data = '0; bus.rready = 0;
        rq0 = {{4{32'h33663366}}, {4{32'h22442244}}};
        rq1 = {{4{32'hCAFEF00D}}, {4{32'h0BADBEEF}}};
        rq2 = {{4{32'h99887766}}, {4{32'h11223344}}};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wready",   256'(bus.wready),   256'd0);
        check("rst_rq_ready", 256'(bus.rq_ready), 256'd0);
        check("rst_wq_valid", 256'(bus.wq_valid), 256'd0);
        check("rst_rvalid",   256'(bus.rvalid),   256'd0);
        check("rst_rlast",    256'(bus.rlast),    256'd0);
        check("rst_wq_data",  bus.wq_data,        256'd0);
        check("rst_rdata",    256'(bus.rdata),    256'd0);
        check("rst_pslverr",  256'(bus.pslverr),  256'd0);
        check("rst_prdata",   256'(bus.prdata),   256'd0);
        rst = 1'b0;
        @(negedge clk);
        check("pready", 256'(bus.pready), 256'd1);
        apb(0, 12'h004, 0, rd, err); check("ctrl_rst", 256'(rd), 256'd1);
        apb(0, 12'h008, 0, rd, err); check("status_rst", 256'(rd), 256'd0);

        // Normal two-beat write, queue held off
        w_beat(4'd0, 128'h5555_5555_6666_6666_7777_7777_8888_8888, 16'hFFFF, 0);
        w_beat(4'd0, 128'h1111_1111_2222_2222_3333_3333_4444_4444, 16'hFFFF, 1);
        check("wq_valid", 256'(bus.wq_valid), 256'd1);
        check("wq_data", bus.wq_data,
              256'h1111_1111_2222_2222_3333_3333_4444_4444_5555_5555_6666_6666_7777_7777_8888_8888);
        check("wq_strb", 256'(bus.wq_strb), 256'hFFFF_FFFF);
        check("wq_id",   256'(bus.wq_id),   256'd0);
        #1 check("wready_full", 256'(bus.wready), 256'd0);
        @(negedge clk);
        wq_take();

        // Early wlast on beat0
        w_beat(4'd3, 128'hA, 16'hFFFF, 1);
        check("early_data", bus.wq_data, 256'hA);
        check("early_strb", 256'(bus.wq_strb), 256'h0000_FFFF);
        check("early_id",   256'(bus.wq_id),   256'd3);
        apb(0, 12'h008, 0, rd, err); check("werr_set", 256'(rd), 256'd1);
        wq_take();
        apb(1, 12'h008, 1, rd, err); check("w1c_err", 256'(err), 256'd0);
        apb(0, 12'h008, 0, rd, err); check("werr_clr", 256'(rd), 256'd0);

        // APB decode
        apb(0, 12'h00C, 0, rd, err); check("wcnt2", 256'(rd), 256'd2);
        apb(1, 12'h00C, 32'h55, rd, err); check("wcnt_ro_err", 256'(err), 256'd1);
        apb(0, 12'h00C, 0, rd, err); check("wcnt_kept", 256'(rd), 256'd2);
        apb(0, 12'h020, 0, rd, err);
        check("unmapped_err", 256'(err), 256'd1);
        check("unmapped_rd",  256'(rd),  256'd0);
        apb(0, 12'h000, 0, rd, err); check("id_reg", 256'(rd), 256'h5341_4C31);

        // Missing wlast on beat1; beat1 id ignored
        w_beat(4'd7, 128'hA0, 16'h00FF, 0);
        w_beat(4'd9, 128'hA1, 16'hF000, 0);
        check("nolast_data", bus.wq_data, {128'hA1, 128'hA0});
        check("nolast_strb", 256'(bus.wq_strb), 256'hF000_00FF);
        check("nolast_id",   256'(bus.wq_id),   256'd7);
        apb(0, 12'h008, 0, rd, err); check("werr_nolast", 256'(rd), 256'd1);
        wq_take();
        apb(0, 12'h00C, 0, rd, err); check("wcnt3", 256'(rd), 256'd3);

        // Single read split, rready high
        bus.rready = 1'b1; bus.rq_valid = 1'b1; bus.rq_id = 4'd1; bus.rq_data = rq0;
        #1 check("rq_ready_idle", 256'(bus.rq_ready), 256'd1);
        @(negedge clk); bus.rq_valid = 1'b0;
        chk_r("rd_lo", {4{32'h22442244}}, 4'd1, 0);
        @(negedge clk);
        chk_r("rd_hi", {4{32'h33663366}}, 4'd1, 1);
        @(negedge clk);
        check("rd_done", 256'(bus.rvalid), 256'd0);
        apb(0, 12'h010, 0, rd, err); check("rcnt1", 256'(rd), 256'd1);

        // Backpressure on R holds outputs stable
        bus.rready = 1'b0; bus.rq_valid = 1'b1; bus.rq_id = 4'd2; bus.rq_data = rq1;
        @(negedge clk); bus.rq_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_r("stall", {4{32'h0BADBEEF}}, 4'd2, 0);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        chk_r("stall_hi", {4{32'hCAFEF00D}}, 4'd2, 1);
        @(negedge clk);
        check("stall_done", 256'(bus.rvalid), 256'd0);
        apb(0, 12'h010, 0, rd, err); check("rcnt2", 256'(rd), 256'd2);

        // Reset mid-burst discards partial write and read
        w_beat(4'd4, 128'hBEEF, 16'hFFFF, 0);
        bus.rready = 1'b0; bus.rq_valid = 1'b1; bus.rq_id = 4'd5; bus.rq_data = rq2;
        @(negedge clk); bus.rq_valid = 1'b0;
        check("mid_rvalid", 256'(bus.rvalid), 256'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid",   256'(bus.rvalid),   256'd0);
        check("mid_rst_wq_valid", 256'(bus.wq_valid), 256'd0);
        apb(0, 12'h010, 0, rd, err); check("rcnt_rst", 256'(rd), 256'd0);
        apb(0, 12'h00C, 0, rd, err); check("wcnt_rst", 256'(rd), 256'd0);
        w_beat(4'd6, 128'hC0, 16'hFFFF, 0);
        w_beat(4'd6, 128'hC1, 16'hFFFF, 1);
        check("post_rst_data", bus.wq_data, {128'hC1, 128'hC0});
        wq_take();

        // Two reads back to back, no bubble
        bus.rready = 1'b1; bus.rq_valid = 1'b1; bus.rq_id = 4'd0; bus.rq_data = rq1;
        @(negedge clk);
        bus.rq_id = 4'd1; bus.rq_data = rq2;
        chk_r("b2b0_lo", {4{32'h0BADBEEF}}, 4'd0, 0);
        @(negedge clk);
        chk_r("b2b0_hi", {4{32'hCAFEF00D}}, 4'd0, 1);
        check("b2b_rq_ready", 256'(bus.rq_ready), 256'd1);
        @(negedge clk);
        bus.rq_valid = 1'b0;
        chk_r("b2b1_lo", {4{32'h11223344}}, 4'd1, 0);
        @(negedge clk);
        chk_r("b2b1_hi", {4{32'h99887766}}, 4'd1, 1);
        @(negedge clk);
        check("b2b_done", 256'(bus.rvalid), 256'd0);
        apb(0, 12'h010, 0, rd, err); check("rcnt_b2b", 256'(rd), 256'd2);

        // EN=0 blocks both paths
        apb(1, 12'h004, 0, rd, err); check("ctrl_wr_err", 256'(err), 256'd0);
        apb(0, 12'h004, 0, rd, err); check("ctrl_off", 256'(rd), 256'd0);
        bus.wvalid = 1'b1; bus.rq_valid = 1'b1;
        #1;
        check("dis_wready",   256'(bus.wready),   256'd0);
        check("dis_rq_ready", 256'(bus.rq_ready), 256'd0);
        @(negedge clk);
        bus.wvalid = 1'b0; bus.rq_valid = 1'b0;
        check("dis_wq_valid", 256'(bus.wq_valid), 256'd0);
        check("dis_rvalid",   256'(bus.rvalid),   256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
